// File: rtl/awb_gain_stat.sv
// Gray-world AWB statistics: sums R/G/B per frame, then divides sequentially into Q8.8 gains.
// Optional `AWB_SMOOTH_EN blends each new gain with the previous one as (3*old + new) >> 2.
module awb_gain_stat (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_vsync,
    input  logic        in_hsync,
    input  logic        in_den,
    input  logic [7:0]  in_data_R,
    input  logic [7:0]  in_data_G,
    input  logic [7:0]  in_data_B,
    output logic [15:0] gain_R,
    output logic [15:0] gain_B,
    output logic        gain_valid,
    output logic        busy
);

    localparam logic [15:0] MAX_GAIN = 16'h0400;
    localparam logic [15:0] UNITY    = 16'h0100;
    localparam logic [5:0]  LAST_IT  = 6'd39;

    typedef enum logic [1:0] {IDLE, DIV_R, DIV_B, UPDATE} state_t;

    state_t      state_q, state_d;
    logic        r_vsync_q, rr_vsync_q, r_den_q, r_hsync_unused_q;
    logic [7:0]  r_data_r_q, r_data_g_q, r_data_b_q;
    logic [31:0] acc_r_q, acc_r_d, acc_g_q, acc_g_d, acc_b_q, acc_b_d;
    logic [19:0] pix_cnt_q, pix_cnt_d;
    logic [31:0] snap_r_q, snap_r_d, snap_g_q, snap_g_d, snap_b_q, snap_b_d;
    logic [39:0] quo_q, quo_d;
    logic [31:0] rem_q, rem_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [15:0] res_r_q, res_r_d;
    logic [15:0] gain_r_q, gain_r_d, gain_b_q, gain_b_d;
    logic        gain_valid_q, gain_valid_d;

    logic        vs_rise;
    logic [31:0] divisor;
    logic [32:0] rem_shift, rem_sub;
    logic        take;
    logic [31:0] rem_step;
    logic [39:0] quo_step;

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [7:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {25'd0, b};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

    // Zero divisor yields unity gain rather than the all-ones quotient the divider produces.
    function automatic logic [15:0] clamp_gain(input logic [39:0] q, input logic [31:0] d);
        logic [15:0] g;
        if (d == 32'd0)
            g = UNITY;
        else if (q > {24'd0, MAX_GAIN})
            g = MAX_GAIN;
        else
            g = q[15:0];
        return g;
    endfunction

    function automatic logic [15:0] apply_gain(input logic [15:0] old_g, input logic [15:0] new_g);
`ifdef AWB_SMOOTH_EN
        logic [17:0] s;
        s = {2'b00, old_g} + {1'b0, old_g, 1'b0} + {2'b00, new_g};
        return s[17:2];
`else
        logic [15:0] unused_old;
        unused_old = old_g;
        return new_g;
`endif
    endfunction

    assign vs_rise = r_vsync_q & ~rr_vsync_q;

    // One restoring-divide step: shift in the next dividend bit, subtract if it fits.
    assign divisor   = (state_q == DIV_B) ? snap_b_q : snap_r_q;
    assign rem_shift = {rem_q, quo_q[39]};
    assign rem_sub   = rem_shift - {1'b0, divisor};
    assign take      = (rem_shift >= {1'b0, divisor});
    assign rem_step  = take ? rem_sub[31:0] : rem_shift[31:0];
    assign quo_step  = {quo_q[38:0], take};

    always_comb begin
        acc_r_d      = acc_r_q;
        acc_g_d      = acc_g_q;
        acc_b_d      = acc_b_q;
        pix_cnt_d    = pix_cnt_q;
        snap_r_d     = snap_r_q;
        snap_g_d     = snap_g_q;
        snap_b_d     = snap_b_q;
        quo_d        = quo_q;
        rem_d        = rem_q;
        cnt_d        = cnt_q;
        res_r_d      = res_r_q;
        gain_r_d     = gain_r_q;
        gain_b_d     = gain_b_q;
        gain_valid_d = 1'b0;
        state_d      = state_q;

        // A pixel coincident with the frame boundary opens the new frame.
        if (vs_rise) begin
            acc_r_d   = r_den_q ? {24'd0, r_data_r_q} : 32'd0;
            acc_g_d   = r_den_q ? {24'd0, r_data_g_q} : 32'd0;
            acc_b_d   = r_den_q ? {24'd0, r_data_b_q} : 32'd0;
            pix_cnt_d = r_den_q ? 20'd1 : 20'd0;
        end else if (r_den_q) begin
            acc_r_d   = sat_add(acc_r_q, r_data_r_q);
            acc_g_d   = sat_add(acc_g_q, r_data_g_q);
            acc_b_d   = sat_add(acc_b_q, r_data_b_q);
            pix_cnt_d = (pix_cnt_q == 20'hF_FFFF) ? pix_cnt_q : pix_cnt_q + 20'd1;
        end

        unique case (state_q)
            IDLE: begin
                if (vs_rise && (pix_cnt_q != 20'd0)) begin
                    snap_r_d = acc_r_q;
                    snap_g_d = acc_g_q;
                    snap_b_d = acc_b_q;
                    quo_d    = {acc_g_q, 8'h00};
                    rem_d    = 32'd0;
                    cnt_d    = 6'd0;
                    state_d  = DIV_R;
                end
            end
            DIV_R: begin
                quo_d = quo_step;
                rem_d = rem_step;
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == LAST_IT) begin
                    res_r_d = clamp_gain(quo_step, snap_r_q);
                    quo_d   = {snap_g_q, 8'h00};
                    rem_d   = 32'd0;
                    cnt_d   = 6'd0;
                    state_d = DIV_B;
                end
            end
            DIV_B: begin
                quo_d = quo_step;
                rem_d = rem_step;
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == LAST_IT) begin
                    cnt_d   = 6'd0;
                    state_d = UPDATE;
                end
            end
            UPDATE: begin
                gain_r_d     = apply_gain(gain_r_q, res_r_q);
                gain_b_d     = apply_gain(gain_b_q, clamp_gain(quo_q, snap_b_q));
                gain_valid_d = 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_vsync_q        <= 1'b0;
            rr_vsync_q       <= 1'b0;
            r_den_q          <= 1'b0;
            r_hsync_unused_q <= 1'b0;
            r_data_r_q       <= 8'd0;
            r_data_g_q       <= 8'd0;
            r_data_b_q       <= 8'd0;
            acc_r_q          <= 32'd0;
            acc_g_q          <= 32'd0;
            acc_b_q          <= 32'd0;
            pix_cnt_q        <= 20'd0;
            snap_r_q         <= 32'd0;
            snap_g_q         <= 32'd0;
            snap_b_q         <= 32'd0;
            quo_q            <= 40'd0;
            rem_q            <= 32'd0;
            cnt_q            <= 6'd0;
            res_r_q          <= UNITY;
            gain_r_q         <= UNITY;
            gain_b_q         <= UNITY;
            gain_valid_q     <= 1'b0;
            state_q          <= IDLE;
        end else begin
            r_vsync_q        <= in_vsync;
            rr_vsync_q       <= r_vsync_q;
            r_den_q          <= in_den;
            r_hsync_unused_q <= in_hsync;
            r_data_r_q       <= in_data_R;
            r_data_g_q       <= in_data_G;
            r_data_b_q       <= in_data_B;
            acc_r_q          <= acc_r_d;
            acc_g_q          <= acc_g_d;
            acc_b_q          <= acc_b_d;
            pix_cnt_q        <= pix_cnt_d;
            snap_r_q         <= snap_r_d;
            snap_g_q         <= snap_g_d;
            snap_b_q         <= snap_b_d;
            quo_q            <= quo_d;
            rem_q            <= rem_d;
            cnt_q            <= cnt_d;
            res_r_q          <= res_r_d;
            gain_r_q         <= gain_r_d;
            gain_b_q         <= gain_b_d;
            gain_valid_q     <= gain_valid_d;
            state_q          <= state_d;
        end
    end

    assign gain_R     = gain_r_q;
    assign gain_B     = gain_b_q;
    assign gain_valid = gain_valid_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_awb_gain_stat.sv
// Self-checking bench for awb_gain_stat: table of 4x4 frames plus busy-discard, blank-frame and reset sequences.
// Expected gains go into a scoreboard queue at each vsync rise and are matched against gain_valid pulses.
module tb_awb_gain_stat;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_vsync = 1'b0;
    logic        in_hsync = 1'b0;
    logic        in_den = 1'b0;
    logic [7:0]  in_data_R = 8'd0;
    logic [7:0]  in_data_G = 8'd0;
    logic [7:0]  in_data_B = 8'd0;
    logic [15:0] gain_R, gain_B;
    logic        gain_valid, busy;

    always #5 clk = ~clk;

    awb_gain_stat dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_vsync   (in_vsync),
        .in_hsync   (in_hsync),
        .in_den     (in_den),
        .in_data_R  (in_data_R),
        .in_data_G  (in_data_G),
        .in_data_B  (in_data_B),
        .gain_R     (gain_R),
        .gain_B     (gain_B),
        .gain_valid (gain_valid),
        .busy       (busy)
    );

    typedef struct {
        logic [15:0] gr;
        logic [15:0] gb;
        int          due;
    } exp_t;

    typedef struct {
        logic [7:0]  r;
        logic [7:0]  g;
        logic [7:0]  b;
        logic [15:0] er;
        logic [15:0] eb;
    } vec_t;

    exp_t        sb[$];
    vec_t        vecs[6];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic [15:0] model_r = 16'h0100;
    logic [15:0] model_b = 16'h0100;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] next_gain(input logic [15:0] old_g, input logic [15:0] raw);
`ifdef AWB_SMOOTH_EN
        return 16'((3 * int'(old_g) + int'(raw)) / 4);
`else
        return (old_g == old_g) ? raw : raw;
`endif
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (reset_n && gain_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: got gain_valid=1 expected 0 (cycle %0d)", cyc);
            end else begin
                e = sb.pop_front();
                $display("pulse cycle %0d gain_R=%04h gain_B=%04h", cyc, gain_R, gain_B);
                check("gain_R", 40'(gain_R), 40'(e.gr));
                check("gain_B", 40'(gain_B), 40'(e.gb));
                check("pulse_cycle", 40'(cyc), 40'(e.due));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_pixels(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b, input logic den);
        for (int ln = 0; ln < 4; ln++) begin
            in_hsync = 1'b1;
            tick(1);
            in_hsync = 1'b0;
            for (int px = 0; px < 4; px++) begin
                in_den    = den;
                in_data_R = r;
                in_data_G = g;
                in_data_B = b;
                tick(1);
            end
            in_den = 1'b0;
            tick(2);
        end
    endtask

    task automatic vsync_rise(output int c);
        in_vsync = 1'b1;
        c = cyc;
        tick(3);
        in_vsync = 1'b0;
    endtask

    task automatic push_exp(input logic [15:0] er, input logic [15:0] eb, input int c);
        exp_t e;
        model_r = next_gain(model_r, er);
        model_b = next_gain(model_b, eb);
        e.gr  = model_r;
        e.gb  = model_b;
        e.due = c + 83;
        sb.push_back(e);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 300) begin
            tick(1);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending results expected 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        int c;
        vecs[0] = '{8'd128, 8'd128, 8'd128, 16'h0100, 16'h0100};
        vecs[1] = '{8'd64,  8'd128, 8'd32,  16'h0200, 16'h0400};
        vecs[2] = '{8'd16,  8'd128, 8'd0,   16'h0400, 16'h0100};
        vecs[3] = '{8'd128, 8'd64,  8'd255, 16'h0080, 16'h0040};
        vecs[4] = '{8'd0,   8'd128, 8'd200, 16'h0100, 16'h00A3};
        vecs[5] = '{8'd255, 8'd1,   8'd3,   16'h0001, 16'h0055};

        tick(3);
        reset_n = 1'b1;
        tick(1);
        check("reset_gain_R", 40'(gain_R), 40'h0100);
        check("reset_gain_B", 40'(gain_B), 40'h0100);
        check("reset_valid", 40'(gain_valid), 40'h0);
        check("reset_busy", 40'(busy), 40'h0);

        for (int i = 0; i < 6; i++) begin
            send_pixels(vecs[i].r, vecs[i].g, vecs[i].b, 1'b1);
            vsync_rise(c);
            $display("frame %0d R=%0d G=%0d B=%0d vsync at cycle %0d", i, vecs[i].r, vecs[i].g, vecs[i].b, c);
            push_exp(vecs[i].er, vecs[i].eb, c);
            tick(10);
            check("busy_during_div", 40'(busy), 40'h1);
            wait_drain();
            tick(10);
            check("busy_after_update", 40'(busy), 40'h0);
        end

        // Blank frame: no pixels, no update.
        send_pixels(8'd50, 8'd60, 8'd70, 1'b0);
        vsync_rise(c);
        $display("blank frame vsync at cycle %0d", c);
        tick(120);
        check("blank_gain_R", 40'(gain_R), 40'(model_r));
        check("blank_gain_B", 40'(gain_B), 40'(model_b));
        check("blank_busy", 40'(busy), 40'h0);

        // Second vsync 30 cycles into the divide: its frame is discarded.
        send_pixels(8'd64, 8'd128, 8'd128, 1'b1);
        vsync_rise(c);
        $display("busy test first vsync at cycle %0d", c);
        push_exp(16'h0200, 16'h0100, c);
        tick(2);
        for (int k = 0; k < 20; k++) begin
            in_den    = 1'b1;
            in_data_R = 8'd128;
            in_data_G = 8'd128;
            in_data_B = 8'd64;
            tick(1);
        end
        in_den = 1'b0;
        tick(5);
        check("busy_at_second_vsync", 40'(busy), 40'h1);
        vsync_rise(c);
        $display("busy test second vsync at cycle %0d", c);
        wait_drain();
        tick(150);
        check("busy_after_discard", 40'(busy), 40'h0);
        check("discard_gain_R", 40'(gain_R), 40'(model_r));

        // Reset at E+20 aborts the divide.
        send_pixels(8'd255, 8'd128, 8'd64, 1'b1);
        vsync_rise(c);
        $display("reset test vsync at cycle %0d", c);
        tick(18);
        check("busy_before_reset", 40'(busy), 40'h1);
        reset_n = 1'b0;
        tick(2);
        check("abort_gain_R", 40'(gain_R), 40'h0100);
        check("abort_gain_B", 40'(gain_B), 40'h0100);
        check("abort_busy", 40'(busy), 40'h0);
        reset_n = 1'b1;
        model_r = 16'h0100;
        model_b = 16'h0100;
        tick(120);
        check("post_reset_gain_R", 40'(gain_R), 40'h0100);
        check("post_reset_busy", 40'(busy), 40'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
